// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder and its future initiators.
// Contents: responder state encoding, default physical memory window,
// and the request record carried from initiator to responder.
package mem_responder_pkg;

  localparam int unsigned ADDR_W_DEF = 64;
  localparam int unsigned DATA_W_DEF = 64;

  localparam logic [63:0] MEM_BASE_DEF = 64'h0000_0000_8000_0000;
  localparam logic [63:0] MEM_SIZE_DEF = 64'h0000_0000_0800_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]   addr;
    logic                    wen;
    logic [DATA_W_DEF-1:0]   wdata;
    logic [DATA_W_DEF/8-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Interfaces around the memory responder.
//   mem_responder_if      : request/response valid-ready channels.
//     master = initiator (PC/LSU), slave = responder.
//   mem_responder_vmem_if : access port toward the simulated physical memory.
//     host = responder, model = memory.
//     rd/wr are single-cycle strobes sampled at the commit edge; rdata is
//     combinational from addr and is captured by the responder on that edge.
interface mem_responder_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_wen;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface mem_responder_vmem_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                rd;
  logic                wr;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wmask;
  logic [DATA_W-1:0]   rdata;

  modport host  (output rd, wr, addr, wdata, wmask, input rdata);
  modport model (input rd, wr, addr, wdata, wmask, output rdata);
endinterface

// File: rtl/mem_responder_range_check.sv
// mem_range_check: combinational test of a byte address against the
// window [MEM_BASE, MEM_BASE+MEM_SIZE).
//   addr     in  ADDR_W  byte address
//   in_range out 1       1 when addr lies inside the window
module mem_range_check
  import mem_responder_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] MEM_BASE = ADDR_W'(MEM_BASE_DEF),
  parameter logic [ADDR_W-1:0] MEM_SIZE = ADDR_W'(MEM_SIZE_DEF)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  logic [ADDR_W-1:0] offset;

  // Offset wraps for addresses below the base; the first term rejects those.
  assign offset   = addr - MEM_BASE;
  assign in_range = (addr >= MEM_BASE) && (offset < MEM_SIZE);

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder for fetch/load/store.
// Accepts a request, waits, performs one access on the memory port, then
// holds the response until the initiator takes it.
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset
//   bus   slave modport of mem_responder_if (request/response channels)
//   vmem  host modport of mem_responder_vmem_if (simulated memory access)
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request handshake
// WAIT    | request latched, counting down to the commit edge
// RESP    | response presented, waiting for rsp_ready
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                DATA_W   = 64,
  parameter int                LATENCY  = 1,
  parameter logic [ADDR_W-1:0] MEM_BASE = ADDR_W'(MEM_BASE_DEF),
  parameter logic [ADDR_W-1:0] MEM_SIZE = ADDR_W'(MEM_SIZE_DEF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_responder_if.slave        bus,
  mem_responder_vmem_if.host    vmem
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(LATENCY + 1);
  // Counter covers the accept-to-commit wait plus the commit cycle, so the
  // response appears LATENCY+1 edges after the accepting edge.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;

  logic                accept;
  logic                commit;
  logic                in_range;

  mem_range_check #(
    .ADDR_W   (ADDR_W),
    .MEM_BASE (MEM_BASE),
    .MEM_SIZE (MEM_SIZE)
  ) u_range (
    .addr     (addr_q),
    .in_range (in_range)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    accept      = 1'b0;
    commit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Raises req_ready on the first edge after reset release.
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          accept      = 1'b1;
          state_d     = ST_WAIT;
          cnt_d       = CNT_LOAD;
          req_ready_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          commit      = 1'b1;
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          err_d       = !in_range;
          rdata_d     = (in_range && !wen_q) ? vmem.rdata : '0;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (accept) begin
      addr_q  <= bus.req_addr;
      wen_q   <= bus.req_wen;
      wdata_q <= bus.req_wdata;
      wmask_q <= bus.req_wmask;
    end
  end

  assign vmem.rd    = commit && in_range && !wen_q;
  assign vmem.wr    = commit && in_range && wen_q;
  assign vmem.addr  = addr_q;
  assign vmem.wdata = wdata_q;
  assign vmem.wmask = wmask_q;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule
